// File: rtl/mtimer_periph.sv
// rtl/mtimer_periph.sv - RISC-V machine timer (mtime/mtimecmp) on the nanorv32 native bus
// Single-cycle registered acknowledge; level interrupt when mtime >= mtimecmp.
module mtimer_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        timer_irq
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   localparam logic [5:0] OFF_MTIME_LO = 6'h00;
   localparam logic [5:0] OFF_MTIME_HI = 6'h01;
   localparam logic [5:0] OFF_CMP_LO   = 6'h02;
   localparam logic [5:0] OFF_CMP_HI   = 6'h03;
   localparam logic [5:0] OFF_CTRL     = 6'h04;

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic [31:0] r_hi_shadow;
   logic [15:0] r_pcnt;
   logic        r_en;

   logic        w_sel;
   logic        w_acc;
   logic        w_wr;
   logic        w_rd;
   logic [5:0]  w_off;
   logic        w_tick;
   logic        w_ctrl_wr;
   logic [31:0] w_rvalue;
   logic        w_unused;

   assign w_sel     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
   assign w_acc     = w_sel && !mem_ready;
   assign w_wr      = w_acc && (mem_wstrb != 4'b0000);
   assign w_rd      = w_acc && (mem_wstrb == 4'b0000);
   assign w_off     = mem_addr[7:2];
   assign w_tick    = r_en && (r_pcnt == PS_LAST);
   assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL) && mem_wstrb[0];
   assign w_unused  = ^mem_addr[1:0];

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      return res;
   endfunction

   always_comb begin
      w_rvalue = 32'h0;
      case (w_off)
         OFF_MTIME_LO: w_rvalue = r_mtime[31:0];
         OFF_MTIME_HI: w_rvalue = r_hi_shadow;
         OFF_CMP_LO:   w_rvalue = r_mtimecmp[31:0];
         OFF_CMP_HI:   w_rvalue = r_mtimecmp[63:32];
         OFF_CTRL:     w_rvalue = {30'h0, timer_irq, r_en};
         default:      w_rvalue = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mtime     <= 64'h0;
         r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_hi_shadow <= 32'h0;
         r_pcnt      <= 16'h0;
         r_en        <= 1'b0;
         mem_ready   <= 1'b0;
         mem_rdata   <= 32'h0;
         timer_irq   <= 1'b0;
      end else begin
         mem_ready <= w_acc;
         mem_rdata <= w_rd ? w_rvalue : 32'h0;
         timer_irq <= (r_mtime >= r_mtimecmp);

         // Capture the upper half on the low read so a later HI read is carry-coherent
         if (w_rd && (w_off == OFF_MTIME_LO))
            r_hi_shadow <= r_mtime[63:32];

         if (w_ctrl_wr)
            r_en <= mem_wdata[0];

         if ((w_ctrl_wr && !mem_wdata[0]) || !r_en || w_tick)
            r_pcnt <= 16'h0;
         else
            r_pcnt <= r_pcnt + 16'h1;

         // A CPU write to either mtime half wins over the tick for that edge
         if (w_wr && (w_off == OFF_MTIME_LO))
            r_mtime[31:0] <= merge(r_mtime[31:0], mem_wdata, mem_wstrb);
         else if (w_wr && (w_off == OFF_MTIME_HI))
            r_mtime[63:32] <= merge(r_mtime[63:32], mem_wdata, mem_wstrb);
         else if (w_tick)
            r_mtime <= r_mtime + 64'h1;

         if (w_wr && (w_off == OFF_CMP_LO))
            r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], mem_wdata, mem_wstrb);
         if (w_wr && (w_off == OFF_CMP_HI))
            r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], mem_wdata, mem_wstrb);
      end
   end

endmodule
